// File: rtl/priority_n.sv
// Registered leading-one priority encoder: pa = (index of highest set bit of py) + 1,
// or 0 when py is all zeros; pv flags any bit set. One cycle latency, one result per cycle.
module priority_n #(
  parameter  int WIDTH = 8,
  localparam int PAW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] py,
  output logic [PAW-1:0]   pa,
  output logic             pv
);

  logic [PAW-1:0] pa_d, pa_q;
  logic           pv_d, pv_q;

  // Scan low to high so the highest set bit makes the last (winning) assignment;
  // bits below the leading one are overwritten and never reach the result.
  always_comb begin
    pa_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (py[i]) pa_d = PAW'(i + 1);
    end
    pv_d = |py;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_q <= '0;
      pv_q <= 1'b0;
    end else begin
      pa_q <= pa_d;
      pv_q <= pv_d;
    end
  end

  assign pa = pa_q;
  assign pv = pv_q;

endmodule

// File: tb/tb_priority_n.sv
// Self-checking bench for priority_n: scoreboard of {pv, pa} expectations pushed when py
// is driven and popped one cycle later when the registered result appears.
module tb_priority_n;

  localparam int WIDTH = 8;
  localparam int PAW   = $clog2(WIDTH + 1);
  localparam int W     = PAW + 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] py;
  logic [PAW-1:0]   pa;
  logic             pv;

  logic [W-1:0] exp_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  priority_n #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .py    (py),
    .pa    (pa),
    .pv    (pv)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: search from the top bit downward for the first one.
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] v);
    logic [PAW-1:0] a;
    logic           found;
    a = '0;
    found = 1'b0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (!found && v[k]) begin
        a = PAW'(k + 1);
        found = 1'b1;
      end
    end
    return {(v != '0), a};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    rst_n = 1'b0;
    py    = 8'hFF;
    #1;
    tests_run++;
    if ({pv, pa} !== W'(0)) begin
      tests_failed++;
      $display("FAIL reset_async: actual pv=%0b pa=%0d required pv=0 pa=0", pv, pa);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({pv, pa} !== W'(0)) begin
      tests_failed++;
      $display("FAIL reset_hold: actual pv=%0b pa=%0d required pv=0 pa=0", pv, pa);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(py));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if ({pv, pa} !== e || e !== {1'b1, PAW'(8)}) begin
      tests_failed++;
      $display("FAIL reset_release: actual pv=%0b pa=%0d required pv=1 pa=8", pv, pa);
    end
  endtask

  task automatic test_empty();
    logic [W-1:0] e;
    @(negedge clk);
    py = 8'h00;
    exp_q.push_back(model(py));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if ({pv, pa} !== e || e !== W'(0)) begin
      tests_failed++;
      $display("FAIL empty: actual pv=%0b pa=%0d required pv=0 pa=0", pv, pa);
    end
  endtask

  task automatic test_thermometer();
    logic [WIDTH-1:0] v;
    logic [W-1:0]     e;
    for (int i = 0; i <= WIDTH; i++) begin
      @(negedge clk);
      v  = WIDTH'((9'h1 << i) - 9'h1);
      py = v;
      exp_q.push_back(model(py));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({pv, pa} !== e || pa !== PAW'(i)) begin
        tests_failed++;
        $display("FAIL thermo[%0d]: py=%h actual pv=%0b pa=%0d required pv=%0b pa=%0d",
                 i, v, pv, pa, e[PAW], e[PAW-1:0]);
      end
    end
  endtask

  task automatic test_dont_care();
    logic [WIDTH-1:0] vec [4];
    logic [PAW-1:0]   ans [4];
    logic [W-1:0]     e;
    vec[0] = 8'b0000_0101; ans[0] = 3;
    vec[1] = 8'b0010_0001; ans[1] = 6;
    vec[2] = 8'b1000_0000; ans[2] = 8;
    vec[3] = 8'b0000_0010; ans[3] = 2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      py = vec[i];
      exp_q.push_back({1'b1, ans[i]});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({pv, pa} !== e) begin
        tests_failed++;
        $display("FAIL dont_care[%0d]: py=%b actual pv=%0b pa=%0d required pv=1 pa=%0d",
                 i, vec[i], pv, pa, ans[i]);
      end
    end
  endtask

  // Back-to-back random stream; shift spreads leading-one positions across the vector.
  task automatic test_back_to_back_random();
    logic [WIDTH-1:0] v;
    logic [W-1:0]     e;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      v  = WIDTH'($urandom_range(0, 255)) >> $urandom_range(0, WIDTH);
      py = v;
      exp_q.push_back(model(v));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if ({pv, pa} !== e) begin
        tests_failed++;
        $display("FAIL random[%0d]: py=%h actual pv=%0b pa=%0d required pv=%0b pa=%0d",
                 i, v, pv, pa, e[PAW], e[PAW-1:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    @(negedge clk);
    py = 8'h40;
    exp_q.push_back(model(py));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if ({pv, pa} !== e || e !== {1'b1, PAW'(7)}) begin
      tests_failed++;
      $display("FAIL midstream_pre: actual pv=%0b pa=%0d required pv=1 pa=7", pv, pa);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pv, pa} !== W'(0)) begin
      tests_failed++;
      $display("FAIL midstream_async_clear: actual pv=%0b pa=%0d required pv=0 pa=0", pv, pa);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({pv, pa} !== W'(0)) begin
      tests_failed++;
      $display("FAIL midstream_hold: actual pv=%0b pa=%0d required pv=0 pa=0", pv, pa);
    end
    @(negedge clk);
    rst_n = 1'b1;
    py    = 8'h13;
    exp_q.push_back(model(py));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if ({pv, pa} !== e || e !== {1'b1, PAW'(5)}) begin
      tests_failed++;
      $display("FAIL midstream_release: actual pv=%0b pa=%0d required pv=1 pa=5", pv, pa);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b0;
    py    = '0;
    test_reset();
    test_empty();
    test_thermometer();
    test_dont_care();
    test_back_to_back_random();
    test_async_reset();
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: actual %0d entries left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
